// File: rtl/fir_coeff_host_seq.sv
// Host-side sequencer for the FIR controller's coefficient-RAM command port.
// Loads P_NUM_TAPS coefficients over valid/ready, then issues one read burst per sample strobe.
//
// state   | meaning
// S_IDLE  | nothing loaded yet, strobes ignored
// S_ARM   | controller armed for update, waiting for first coefficient
// S_WRITE | burst-writing coefficients, addr = accept index
// S_WEND  | one-cycle end of load, hand controller back to read mode
// S_RUN   | loaded, waiting for a strobe or a reload
// S_READ  | read burst over addr 0..N-1
module fir_coeff_host_seq #(
    parameter int P_NUM_TAPS = 33
) (
    input  logic        iClk_12M,
    input  logic        iRsn,
    input  logic        iLoadReq,
    input  logic        iCoeffValid,
    input  logic [15:0] iCoeffData,
    output logic        oCoeffReady,
    input  logic        iSampleStrobe,
    output logic        oCoeffiUpdateFlag,
    output logic        oCsnRam,
    output logic        oWrnRam,
    output logic [5:0]  oAddrRam,
    output logic [15:0] oWrDtRam,
    output logic        oLoadDone,
    output logic        oSampleDone,
    output logic        oSampleDrop,
    output logic        oCoeffValidTab
);

    localparam logic [5:0] LAST_ADDR = 6'(P_NUM_TAPS - 1);
    localparam logic [6:0] NUM_TAPS  = 7'(P_NUM_TAPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WRITE,
        S_WEND,
        S_RUN,
        S_READ
    } state_t;

    state_t      state_q, state_d;
    logic        flag_q, flag_d;
    logic        csn_q, csn_d;
    logic        wrn_q, wrn_d;
    logic [5:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        load_done_q, load_done_d;
    logic        sample_done_q, sample_done_d;
    logic        sample_drop_q, sample_drop_d;
    logic        valid_tab_q, valid_tab_d;
    logic        strobe_pend_q, strobe_pend_d;
    logic        load_pend_q, load_pend_d;
    logic [6:0]  acc_cnt_q, acc_cnt_d;
    logic        accept;

    always_comb begin
        accept        = iCoeffValid && ready_q;
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        acc_cnt_d     = acc_cnt_q;
        strobe_pend_d = strobe_pend_q;
        load_pend_d   = load_pend_q;
        valid_tab_d   = valid_tab_q;
        load_done_d   = 1'b0;
        sample_done_d = 1'b0;
        sample_drop_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iLoadReq) state_d = S_ARM;
            end
            S_ARM: begin
                sample_drop_d = iSampleStrobe;
                if (accept) begin
                    state_d   = S_WRITE;
                    addr_d    = 6'd0;
                    data_d    = iCoeffData;
                    acc_cnt_d = 7'd1;
                end
            end
            S_WRITE: begin
                sample_drop_d = iSampleStrobe;
                // All N accepted means addr N-1 has now been on the bus for a cycle.
                if (acc_cnt_q == NUM_TAPS) begin
                    state_d     = S_WEND;
                    addr_d      = 6'd0;
                    data_d      = 16'd0;
                    load_done_d = 1'b1;
                    valid_tab_d = 1'b1;
                end else if (accept) begin
                    addr_d    = acc_cnt_q[5:0];
                    data_d    = iCoeffData;
                    acc_cnt_d = acc_cnt_q + 7'd1;
                end
            end
            S_WEND: begin
                sample_drop_d = iSampleStrobe;
                state_d       = S_RUN;
            end
            S_RUN: begin
                if (iLoadReq || load_pend_q) begin
                    // A reload latched during a burst discards the strobe queued behind it.
                    state_d       = S_ARM;
                    sample_drop_d = load_pend_q && strobe_pend_q;
                    strobe_pend_d = 1'b0;
                    load_pend_d   = 1'b0;
                end else if (iSampleStrobe || strobe_pend_q) begin
                    state_d       = S_READ;
                    addr_d        = 6'd0;
                    strobe_pend_d = iSampleStrobe && strobe_pend_q;
                end
            end
            S_READ: begin
                if (iLoadReq) load_pend_d = 1'b1;
                if (iSampleStrobe) begin
                    if (strobe_pend_q) sample_drop_d = 1'b1;
                    else               strobe_pend_d = 1'b1;
                end
                if (addr_q == LAST_ADDR) begin
                    state_d       = S_RUN;
                    addr_d        = 6'd0;
                    sample_done_d = 1'b1;
                end else begin
                    addr_d = addr_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        flag_d = 1'b0;
        csn_d  = 1'b1;
        wrn_d  = 1'b1;
        case (state_d)
            S_ARM:   begin flag_d = 1'b1; wrn_d = 1'b0; end
            S_WRITE: begin flag_d = 1'b1; csn_d = 1'b0; wrn_d = 1'b0; end
            S_READ:  csn_d = 1'b0;
            default: ;
        endcase

        ready_d = (state_d == S_ARM) || ((state_d == S_WRITE) && (acc_cnt_d < NUM_TAPS));
    end

    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            state_q       <= S_IDLE;
            flag_q        <= 1'b0;
            csn_q         <= 1'b1;
            wrn_q         <= 1'b1;
            addr_q        <= 6'd0;
            data_q        <= 16'd0;
            ready_q       <= 1'b0;
            load_done_q   <= 1'b0;
            sample_done_q <= 1'b0;
            sample_drop_q <= 1'b0;
            valid_tab_q   <= 1'b0;
            strobe_pend_q <= 1'b0;
            load_pend_q   <= 1'b0;
            acc_cnt_q     <= 7'd0;
        end else begin
            state_q       <= state_d;
            flag_q        <= flag_d;
            csn_q         <= csn_d;
            wrn_q         <= wrn_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            ready_q       <= ready_d;
            load_done_q   <= load_done_d;
            sample_done_q <= sample_done_d;
            sample_drop_q <= sample_drop_d;
            valid_tab_q   <= valid_tab_d;
            strobe_pend_q <= strobe_pend_d;
            load_pend_q   <= load_pend_d;
            acc_cnt_q     <= acc_cnt_d;
        end
    end

    assign oCoeffReady       = ready_q;
    assign oCoeffiUpdateFlag = flag_q;
    assign oCsnRam           = csn_q;
    assign oWrnRam           = wrn_q;
    assign oAddrRam          = addr_q;
    assign oWrDtRam          = data_q;
    assign oLoadDone         = load_done_q;
    assign oSampleDone       = sample_done_q;
    assign oSampleDrop       = sample_drop_q;
    assign oCoeffValidTab    = valid_tab_q;

endmodule

// File: tb/tb_fir_coeff_host_seq.sv
// Bench for fir_coeff_host_seq: one N=4 and one N=33 instance, directed scenarios plus
// randomized loads/bursts checked against a RAM-image and timing model.
module tb_fir_coeff_host_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rsn [2];
    logic        load_req [2];
    logic        cvalid [2];
    logic [15:0] cdata [2];
    logic        strobe [2];
    logic        cready [2];
    logic        flag [2];
    logic        csn [2];
    logic        wrn [2];
    logic [5:0]  addr [2];
    logic [15:0] wdata [2];
    logic        load_done [2];
    logic        sdone [2];
    logic        sdrop [2];
    logic        vtab [2];

    fir_coeff_host_seq #(.P_NUM_TAPS(4)) u_dut4 (
        .iClk_12M(clk), .iRsn(rsn[0]), .iLoadReq(load_req[0]),
        .iCoeffValid(cvalid[0]), .iCoeffData(cdata[0]), .oCoeffReady(cready[0]),
        .iSampleStrobe(strobe[0]), .oCoeffiUpdateFlag(flag[0]), .oCsnRam(csn[0]),
        .oWrnRam(wrn[0]), .oAddrRam(addr[0]), .oWrDtRam(wdata[0]),
        .oLoadDone(load_done[0]), .oSampleDone(sdone[0]), .oSampleDrop(sdrop[0]),
        .oCoeffValidTab(vtab[0])
    );

    fir_coeff_host_seq #(.P_NUM_TAPS(33)) u_dut33 (
        .iClk_12M(clk), .iRsn(rsn[1]), .iLoadReq(load_req[1]),
        .iCoeffValid(cvalid[1]), .iCoeffData(cdata[1]), .oCoeffReady(cready[1]),
        .iSampleStrobe(strobe[1]), .oCoeffiUpdateFlag(flag[1]), .oCsnRam(csn[1]),
        .oWrnRam(wrn[1]), .oAddrRam(addr[1]), .oWrDtRam(wdata[1]),
        .oLoadDone(load_done[1]), .oSampleDone(sdone[1]), .oSampleDrop(sdrop[1]),
        .oCoeffValidTab(vtab[1])
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] cf [2][64];
    logic [15:0] ram [2][64];
    int          ram_gen [2][64];
    int          gen [2];
    int          done_cnt [2];
    int          drop_cnt [2];

    // RAM image as seen by the controller, tagged with the load generation that wrote it.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsn[d] && flag[d] && !csn[d] && !wrn[d]) begin
                ram[d][addr[d]]     <= wdata[d];
                ram_gen[d][addr[d]] <= gen[d];
            end
            if (sdone[d]) done_cnt[d] <= done_cnt[d] + 1;
            if (sdrop[d]) drop_cnt[d] <= drop_cnt[d] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ntaps(input int d);
        return (d == 1) ? 33 : 4;
    endfunction

    task automatic check_cmd(input string tag, input int d, input logic [2:0] exp);
        check(tag, {29'd0, flag[d], csn[d], wrn[d]}, {29'd0, exp});
    endtask

    task automatic check_reset(input string tag, input int d);
        check(tag, {2'd0, flag[d], csn[d], wrn[d], addr[d], wdata[d], cready[d],
                    load_done[d], sdone[d], sdrop[d], vtab[d]},
              {2'd0, 3'b011, 6'd0, 16'd0, 5'd0});
    endtask

    task automatic do_load(input int d, input bit issue_req, input int stall_at,
                           input int stall_len, input bit arm_strobe);
        int n = ntaps(d);
        int k = 0;
        int stall = 0;
        int wcyc = 0;
        int cyc = 0;
        int bad = 0;
        bit acc;
        bit stalling;
        bit done_seen = 1'b0;
        gen[d]++;
        if (issue_req) begin
            load_req[d] = 1'b1;
            tick();
            load_req[d] = 1'b0;
        end
        check_cmd("arm_cmd", d, 3'b110);
        check("arm_ready", cready[d], 1);
        if (arm_strobe) begin
            strobe[d] = 1'b1;
            tick();
            strobe[d] = 1'b0;
            check("arm_drop", sdrop[d], 1);
            check_cmd("arm_hold", d, 3'b110);
        end
        while (!done_seen && cyc < 400) begin
            stalling = (stall > 0);
            if (stalling) stall--;
            cvalid[d] = (k < n) && !stalling;
            cdata[d]  = cvalid[d] ? cf[d][k] : 16'($urandom);
            acc = cvalid[d] && cready[d];
            tick();
            cyc++;
            if (acc) begin
                if (k == stall_at) stall = stall_len;
                k++;
            end
            if ({flag[d], csn[d], wrn[d]} == 3'b100) wcyc++;
            if (load_done[d]) done_seen = 1'b1;
        end
        cvalid[d] = 1'b0;
        check("load_finished", done_seen, 1);
        check_cmd("wend_cmd", d, 3'b011);
        check("wend_vtab", vtab[d], 1);
        check("wend_addr_data", {addr[d], wdata[d]}, 0);
        check("write_len", wcyc, n + stall_len);
        for (int a = 0; a < n; a++)
            if (ram[d][a] !== cf[d][a] || ram_gen[d][a] != gen[d]) bad++;
        check("ram_image", bad, 0);
        tick();
        check_cmd("run_cmd", d, 3'b011);
        check("load_done_once", load_done[d], 0);
    endtask

    task automatic do_read(input int d);
        int n = ntaps(d);
        int bad = 0;
        strobe[d] = 1'b1;
        tick();
        strobe[d] = 1'b0;
        check_cmd("read_cmd", d, 3'b001);
        check("read_addr0", addr[d], 0);
        for (int j = 1; j < n; j++) begin
            tick();
            if ({flag[d], csn[d], wrn[d]} != 3'b001 || addr[d] != 6'(j) ||
                wdata[d] != 16'd0 || sdone[d]) bad++;
        end
        check("read_seq", bad, 0);
        tick();
        check("read_done", sdone[d], 1);
        check_cmd("read_end", d, 3'b011);
    endtask

    task automatic wait_done(input string tag, input int d);
        int cyc = 0;
        while (!sdone[d] && cyc < 200) begin
            tick();
            cyc++;
        end
        check(tag, sdone[d], 1);
    endtask

    initial begin
        int dc0;
        int dr0;
        int k;
        for (int d = 0; d < 2; d++) begin
            rsn[d] = 1'b0; load_req[d] = 1'b0; cvalid[d] = 1'b0;
            cdata[d] = 16'd0; strobe[d] = 1'b0; gen[d] = 0;
        end

        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < 2; d++) begin
                load_req[d] = 1'($urandom_range(0, 1));
                cvalid[d]   = 1'($urandom_range(0, 1));
                cdata[d]    = 16'($urandom);
                strobe[d]   = 1'($urandom_range(0, 1));
            end
            tick();
        end
        check_reset("reset_n4", 0);
        check_reset("reset_n33", 1);
        for (int d = 0; d < 2; d++) begin
            load_req[d] = 1'b0; cvalid[d] = 1'b0; strobe[d] = 1'b0; rsn[d] = 1'b1;
        end
        tick();

        strobe[0] = 1'b1;
        tick();
        strobe[0] = 1'b0;
        check("idle_no_drop", sdrop[0], 0);
        check_cmd("idle_cmd", 0, 3'b011);

        cf[0][0] = 16'h0011; cf[0][1] = 16'hFFFE; cf[0][2] = 16'h7FFF; cf[0][3] = 16'h8000;
        do_load(0, 1'b1, 99, 0, 1'b1);
        do_read(0);

        for (int a = 0; a < 4; a++) cf[0][a] = 16'($urandom);
        do_load(0, 1'b1, 1, 3, 1'b0);

        for (int a = 0; a < 33; a++) cf[1][a] = 16'($urandom);
        do_load(1, 1'b1, 99, 0, 1'b0);
        do_read(1);

        // Overrun: three consecutive strobes on the N=4 instance.
        dc0 = done_cnt[0];
        dr0 = drop_cnt[0];
        strobe[0] = 1'b1;
        tick();
        tick();
        tick();
        strobe[0] = 1'b0;
        check("ovr_drop_pulse", sdrop[0], 1);
        wait_done("ovr_done1", 0);
        tick();
        check_cmd("ovr_b2b_cmd", 0, 3'b001);
        check("ovr_b2b_addr", addr[0], 0);
        wait_done("ovr_done2", 0);
        for (int c = 0; c < 6; c++) tick();
        check("ovr_done_cnt", done_cnt[0] - dc0, 2);
        check("ovr_drop_cnt", drop_cnt[0] - dr0, 1);

        // Reload requested mid-burst, with a strobe queued behind it.
        strobe[0] = 1'b1;
        tick();
        strobe[0] = 1'b0;
        load_req[0] = 1'b1;
        strobe[0] = 1'b1;
        tick();
        load_req[0] = 1'b0;
        strobe[0] = 1'b0;
        check_cmd("reload_still_read", 0, 3'b001);
        wait_done("reload_burst_done", 0);
        check_cmd("reload_run", 0, 3'b011);
        tick();
        check_cmd("reload_arm", 0, 3'b110);
        check("reload_drop", sdrop[0], 1);
        for (int a = 0; a < 4; a++) cf[0][a] = 16'($urandom);
        do_load(0, 1'b0, 99, 0, 1'b0);

        // Reset while address 2 is on the write bus.
        load_req[0] = 1'b1;
        tick();
        load_req[0] = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && !(flag[0] && !csn[0] && addr[0] == 6'd2); c++) begin
            cvalid[0] = 1'b1;
            cdata[0]  = cf[0][k % 4];
            if (cready[0]) k++;
            tick();
        end
        check("rst_mid_reached", {flag[0], csn[0], addr[0]}, {1'b1, 1'b0, 6'd2});
        rsn[0] = 1'b0;
        cdata[0] = 16'($urandom);
        tick();
        check_reset("rst_mid_write", 0);
        rsn[0] = 1'b1;
        cvalid[0] = 1'b0;
        tick();
        tick();
        check("rst_vtab", vtab[0], 0);
        strobe[0] = 1'b1;
        tick();
        strobe[0] = 1'b0;
        check("rst_idle_strobe", {sdrop[0], csn[0]}, 2'b01);

        for (int it = 0; it < 6; it++) begin
            int d = it % 2;
            int n = ntaps(d);
            int reps;
            for (int a = 0; a < n; a++) cf[d][a] = 16'($urandom);
            do_load(d, 1'b1, $urandom_range(0, n - 2), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            reps = $urandom_range(1, 3);
            for (int r = 0; r < reps; r++) begin
                int gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) tick();
                do_read(d);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
